// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default widths, fetch states and
// the decoder opcodes that drive jump/branch/flag/halt controls.
package fetch_unit_pkg;

  localparam int unsigned PC_W   = 10;
  localparam int unsigned LUT_AW = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_BR   = 4'hB;
  localparam logic [3:0] OP_CEQ  = 4'hC;
  localparam logic [3:0] OP_CLT  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/fetch_unit_if.sv
// Control/status bundle between the decoder side (master) and the fetch
// stage (slave).
interface fetch_unit_if #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned LUT_AW = 5
);
  logic              Start;
  logic [PC_W-1:0]   StartAddr;
  logic              jump_en;
  logic              branch_en;
  logic              flag_write;
  logic              flag_in;
  logic              halt;
  logic [LUT_AW-1:0] LutIdx;
  logic              lut_we;
  logic [LUT_AW-1:0] lut_waddr;
  logic [PC_W-1:0]   lut_wdata;
  logic [PC_W-1:0]   ProgCtr;
  logic              Flag;
  logic              Running;
  logic              Done;

  modport master (
    output Start, StartAddr, jump_en, branch_en, flag_write, flag_in, halt,
           LutIdx, lut_we, lut_waddr, lut_wdata,
    input  ProgCtr, Flag, Running, Done
  );

  modport slave (
    input  Start, StartAddr, jump_en, branch_en, flag_write, flag_in, halt,
           LutIdx, lut_we, lut_waddr, lut_wdata,
    output ProgCtr, Flag, Running, Done
  );
endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Branch-target table: async-cleared register file, one synchronous write
// port and one combinational read port.
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W   = fetch_unit_pkg::PC_W,
  parameter int unsigned LUT_AW = fetch_unit_pkg::LUT_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);
  localparam int unsigned DEPTH = 1 << LUT_AW;

  logic [PC_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_unit.sv
// Program counter, compare flag and IDLE/RUN/DONE sequencing for the
// 9-bit-instruction core; jump/branch targets come from branch_lut.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W   = fetch_unit_pkg::PC_W,
  parameter int unsigned LUT_AW = fetch_unit_pkg::LUT_AW
) (
  input  logic   Clk,
  input  logic   Reset_n,
  fetch_unit_if.slave bus
);
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flag_q, flag_d;
  logic            running_q, running_d;
  logic            done_q, done_d;
  logic [PC_W-1:0] lut_rdata;

  // Table is writable only while no program is executing.
  branch_lut #(.PC_W(PC_W), .LUT_AW(LUT_AW)) u_lut (
    .clk   (Clk),
    .rst_n (Reset_n),
    .we    (bus.lut_we && (state_q != RUN)),
    .waddr (bus.lut_waddr),
    .wdata (bus.lut_wdata),
    .raddr (bus.LutIdx),
    .rdata (lut_rdata)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flag_d  = flag_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          pc_d    = bus.StartAddr;
          flag_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Branch tests the already-registered flag, never this cycle's write.
        if (bus.flag_write) flag_d = bus.flag_in;
        if (bus.halt)
          state_d = DONE;
        else if (bus.jump_en || (bus.branch_en && flag_q))
          pc_d = lut_rdata;
        else
          pc_d = pc_q + PC_W'(1);
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      flag_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      flag_q    <= flag_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.ProgCtr = pc_q;
  assign bus.Flag    = flag_q;
  assign bus.Running = running_q;
  assign bus.Done    = done_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues the expected post-edge
// state, an independent monitor pops and compares after every rising edge.
module tb_fetch_unit;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;

  fetch_unit_if #(.PC_W(10), .LUT_AW(5)) bus ();

  fetch_unit #(.PC_W(10), .LUT_AW(5)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [9:0] pc;
    logic       flag;
    logic       run;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input exp_t e);
    n_tests++;
    if (bus.ProgCtr !== e.pc || bus.Flag !== e.flag ||
        bus.Running !== e.run || bus.Done !== e.done) begin
      n_fail++;
      $display("FAIL %s: got pc=%03h flag=%b run=%b done=%b, expected pc=%03h flag=%b run=%b done=%b",
               e.name, bus.ProgCtr, bus.Flag, bus.Running, bus.Done,
               e.pc, e.flag, e.run, e.done);
    end
  endtask

  // Monitor: one expectation per clocked step, compared just after the edge.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) check(exp_q.pop_front());
    end
  end

  task automatic clear_inputs();
    bus.Start = 0; bus.StartAddr = '0; bus.jump_en = 0; bus.branch_en = 0;
    bus.flag_write = 0; bus.flag_in = 0; bus.halt = 0; bus.LutIdx = '0;
    bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;
  endtask

  // Inputs are set by the caller at a falling edge; expectation is for the next rising edge.
  task automatic step(input string name, input logic [9:0] pc, input logic flag,
                      input logic run, input logic done);
    exp_t e;
    e.name = name; e.pc = pc; e.flag = flag; e.run = run; e.done = done;
    exp_q.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    clear_inputs();
  endtask

  task automatic check_now(input string name, input logic [9:0] pc, input logic flag,
                           input logic run, input logic done);
    exp_t e;
    e.name = name; e.pc = pc; e.flag = flag; e.run = run; e.done = done;
    check(e);
  endtask

  initial begin
    clear_inputs();
    #12;
    check_now("reset_state", 10'h000, 0, 0, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    // LUT write and Start in the same IDLE cycle: both take effect.
    bus.lut_we = 1; bus.lut_waddr = 5'd3; bus.lut_wdata = 10'h100;
    bus.Start = 1; bus.StartAddr = 10'h010;
    step("start_010", 10'h010, 0, 1, 0);
    step("seq_011", 10'h011, 0, 1, 0);
    step("seq_012", 10'h012, 0, 1, 0);
    bus.jump_en = 1; bus.LutIdx = 5'd3;
    step("jump_lut3", 10'h100, 0, 1, 0);
    step("seq_101", 10'h101, 0, 1, 0);

    bus.flag_write = 1; bus.flag_in = 0;
    step("flag_wr0", 10'h102, 0, 1, 0);
    bus.branch_en = 1; bus.LutIdx = 5'd3;
    step("branch_not_taken", 10'h103, 0, 1, 0);
    bus.flag_write = 1; bus.flag_in = 1; bus.branch_en = 1; bus.LutIdx = 5'd3;
    step("branch_old_flag", 10'h104, 1, 1, 0);
    // LUT write during RUN must be dropped.
    bus.branch_en = 1; bus.LutIdx = 5'd3;
    bus.lut_we = 1; bus.lut_waddr = 5'd3; bus.lut_wdata = 10'h055;
    step("branch_taken", 10'h100, 1, 1, 0);

    bus.Start = 1; bus.StartAddr = 10'h200;
    step("start_in_run_ignored", 10'h101, 1, 1, 0);
    bus.jump_en = 1; bus.branch_en = 1; bus.halt = 1; bus.LutIdx = 5'd3;
    bus.flag_write = 1; bus.flag_in = 0;
    step("halt_wins", 10'h101, 0, 0, 1);
    bus.lut_we = 1; bus.lut_waddr = 5'd7; bus.lut_wdata = 10'h025;
    step("done_hold", 10'h101, 0, 0, 1);

    bus.Start = 1; bus.StartAddr = 10'h01E;
    step("restart_01e", 10'h01E, 0, 1, 0);
    bus.flag_write = 1; bus.flag_in = 1;
    step("flag_set", 10'h01F, 1, 1, 0);
    step("seq_020", 10'h020, 1, 1, 0);
    bus.halt = 1;
    step("halt_020", 10'h020, 1, 0, 1);
    bus.flag_write = 1; bus.flag_in = 0;
    step("flag_wr_in_done_ignored", 10'h020, 1, 0, 1);

    bus.Start = 1; bus.StartAddr = 10'h3FE;
    step("start_3fe_flag_clr", 10'h3FE, 0, 1, 0);
    step("seq_3ff", 10'h3FF, 0, 1, 0);
    step("wrap_000", 10'h000, 0, 1, 0);
    bus.jump_en = 1; bus.LutIdx = 5'd3;
    step("lut3_unchanged", 10'h100, 0, 1, 0);
    bus.jump_en = 1; bus.LutIdx = 5'd7; bus.flag_write = 1; bus.flag_in = 1;
    step("jump_025", 10'h025, 1, 1, 0);

    // Asynchronous reset in the middle of RUN, checked before any edge.
    #2;
    Reset_n = 1'b0;
    #1;
    check_now("async_reset_mid_run", 10'h000, 0, 0, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    bus.Start = 1; bus.StartAddr = 10'h050;
    step("start_after_reset", 10'h050, 0, 1, 0);
    bus.jump_en = 1; bus.LutIdx = 5'd3;
    step("lut3_cleared", 10'h000, 0, 1, 0);
    bus.jump_en = 1; bus.LutIdx = 5'd7;
    step("lut7_cleared", 10'h000, 0, 1, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch-control stage for the 9-bit-instruction core.
- Sits directly downstream of the control decoder and consumes its jump_en, branch_en and flag_write outputs, plus the ALU compare result.
- Holds the architectural compare flag and a small writable branch-target lookup table (LUT).
- Drives the instruction-ROM address each cycle, and sequences start, run and halt for a program.

Parameters:
- PC_W, 10, width of the program counter and of LUT entries.
- LUT_AW, 5, LUT index width (2^LUT_AW entries).

Ports:
- Clk  in  1  core clock; all state changes on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  single-cycle pulse: begin program at StartAddr.
- StartAddr  in  PC_W  program entry address.
- jump_en  in  1  unconditional jump (from decoder).
- branch_en  in  1  conditional branch (from decoder).
- flag_write  in  1  latch flag_in into Flag (from decoder).
- flag_in  in  1  ALU compare result (CEQ/CLT).
- halt  in  1  decoded halt instruction.
- LutIdx  in  LUT_AW  target index for jump/branch (instruction immediate field).
- lut_we  in  1  LUT write enable.
- lut_waddr  in  LUT_AW  LUT write index.
- lut_wdata  in  PC_W  LUT write data.
- ProgCtr  out  PC_W  instruction-ROM address.
- Flag  out  1  registered compare flag.
- Running  out  1  high in RUN.
- Done  out  1  high in DONE.

Behaviour:
- Reset (async assert, sync-safe deassert) forces:
  - state=IDLE, ProgCtr=0, Flag=0, Running=0, Done=0.
  - All LUT entries cleared to 0.
  - Reset mid-RUN aborts immediately; no partial update.
- States: IDLE, RUN, DONE.
  - IDLE: ProgCtr holds. Start -> ProgCtr<=StartAddr, Flag<=0, next RUN.
  - RUN, evaluated each cycle in this priority:
    1. halt -> next DONE; ProgCtr holds (points at the halt instruction).
    2. jump_en -> ProgCtr<=LUT[LutIdx].
    3. branch_en && Flag -> ProgCtr<=LUT[LutIdx].
    4. Otherwise ProgCtr<=ProgCtr+1, modulo 2^PC_W (all-ones wraps to 0, no error).
  - DONE: Done=1, ProgCtr holds. Start -> same as IDLE start, next RUN.
- Start is ignored while in RUN.
- Flag:
  - In RUN, flag_write -> Flag<=flag_in next edge.
  - Flag holds otherwise, and is cleared on an accepted Start.
  - flag_write is ignored in IDLE and DONE.
- Same-cycle flag_write and branch_en: the branch uses the old registered Flag; the new value is visible next cycle.
- Same-cycle jump_en and branch_en: jump wins; Flag is not consulted.
- halt together with jump_en, branch_en or flag_write: halt wins and Flag is still updated if flag_write is set.
- LUT:
  - Written on the edge when lut_we=1 and state is IDLE or DONE; writes in RUN are dropped.
  - Read is combinational, indexed by LutIdx.
  - A write and an accepted Start in the same cycle: the write takes effect.
- Outputs Running and Done are decoded from the registered state (no combinational input paths).
- Latency: every control input affects ProgCtr exactly one edge later.

Decomposition:
- Shared package (definitions): fetch state enum {IDLE, RUN, DONE}, PC_W and LUT_AW defaults, and opcode constants already used by the decoder.
- One sub-module, branch_lut: 2^LUT_AW x PC_W register file with async clear, one sync write port and one combinational read port.
- fetch_unit contains the FSM, PC and Flag.

Test Plan:
1. Reset_n low mid-RUN at ProgCtr=0x025 -> ProgCtr=0, Flag=0, Running=0 immediately, before any edge; LUT[3] reads 0.
2. In IDLE write LUT[3]=0x100; Start with StartAddr=0x010 -> RUN, ProgCtr sequence 0x010, 0x011, 0x012; jump_en with LutIdx=3 -> next ProgCtr=0x100.
3. flag_write with flag_in=0, then branch_en with LutIdx=3 -> ProgCtr+1. flag_write with flag_in=1 and branch_en in the same cycle -> not taken. branch_en next cycle -> ProgCtr=0x100.
4. StartAddr=0x3FE with no control inputs -> 0x3FE, 0x3FF, 0x000 (wrap).
5. halt at ProgCtr=0x020 -> DONE, Done=1, ProgCtr stays 0x020. lut_we in RUN earlier -> entry unchanged. Start in DONE -> RUN at StartAddr with Flag=0.
6. jump_en, branch_en and halt all asserted together -> DONE, ProgCtr unchanged. Start pulsed during RUN -> ignored.
